// File: rtl/uart_receiving_msg_pkg.sv
// Shared definitions for the UART message receiver: byte FSM states and the
// bit-period arithmetic that must match the sending side exactly.
package uart_receiving_msg_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   // Truncating division, identical on both ends of the link.
   function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                              input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

   function automatic int unsigned half_cycles(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
      return bit_cycles(clk_freq, baud_rate) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchroniser, start-bit qualification, LSB-first
// shift register and stop-bit check.
module uart_rx_byte
   import uart_receiving_msg_pkg::*;
#(
   parameter int unsigned clk_freq  = 1000000,
   parameter int unsigned baud_rate = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_error,
   output logic       idle
);

   localparam int unsigned BIT  = bit_cycles(clk_freq, baud_rate);
   localparam int unsigned HALF = half_cycles(clk_freq, baud_rate);
   localparam int unsigned CW   = $clog2(BIT + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   logic          rx_meta;
   logic          rx_s;
   logic          rx_d;
   rx_state_t     state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;

   assign idle = (state == RX_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta     <= 1'b1;
         rx_s        <= 1'b1;
         rx_d        <= 1'b1;
         state       <= RX_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         byte_data   <= '0;
         byte_valid  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         rx_meta     <= rx;
         rx_s        <= rx_meta;
         rx_d        <= rx_s;
         byte_valid  <= 1'b0;
         frame_error <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (rx_d && !rx_s) begin
                  state   <= RX_START;
                  cnt     <= '0;
                  bit_idx <= '0;
               end
            end
            RX_START: begin
               // A start bit that is high again at its midpoint was a glitch.
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= '0;
                  shift   <= {rx_s, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= RX_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_STOP: begin
               // Leaving at the stop-bit midpoint lets a back-to-back start edge be seen.
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     byte_data  <= shift;
                     byte_valid <= 1'b1;
                     state      <= RX_IDLE;
                  end else begin
                     frame_error <= 1'b1;
                     state       <= RX_WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_WAIT_HIGH: begin
               if (rx_s) state <= RX_IDLE;
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_receiving_msg.sv
// Multi-byte UART message receiver: assembles msg_size_byte bytes (first byte
// in the low bits) and discards partial messages on frame error or idle gap.
module uart_receiving_msg
   import uart_receiving_msg_pkg::*;
#(
   parameter int unsigned clk_freq      = 1000000,
   parameter int unsigned baud_rate     = 9600,
   parameter int unsigned msg_size_byte = 6,
   parameter int unsigned timeout_bits  = 20
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         rx,
   output logic [8*msg_size_byte-1:0]   msg,
   output logic                         done,
   output logic                         busy,
   output logic                         frame_error,
   output logic                         timeout
);

   localparam int unsigned BIT         = bit_cycles(clk_freq, baud_rate);
   localparam int unsigned TIMEOUT_CYC = timeout_bits * BIT;
   localparam int unsigned CNT_W       = (msg_size_byte > 1) ? $clog2(msg_size_byte) : 1;
   localparam int unsigned GAP_W       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(msg_size_byte - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYC - 1);

   logic [7:0]                 byte_data;
   logic                       byte_valid;
   logic                       byte_ferr;
   logic                       rx_idle;
   logic [CNT_W-1:0]           byte_cnt;
   logic [GAP_W-1:0]           gap_cnt;
   logic [8*msg_size_byte-1:0] buf_q;
   logic [8*msg_size_byte-1:0] buf_next;

   uart_rx_byte #(
      .clk_freq  (clk_freq),
      .baud_rate (baud_rate)
   ) u_rx_byte (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .byte_data   (byte_data),
      .byte_valid  (byte_valid),
      .frame_error (byte_ferr),
      .idle        (rx_idle)
   );

   assign frame_error = byte_ferr;
   assign busy        = (byte_cnt != '0) || !rx_idle;

   // The completing byte goes straight into msg without a buffer round trip.
   always_comb begin
      buf_next = buf_q;
      buf_next[{byte_cnt, 3'b000} +: 8] = byte_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         msg      <= '0;
         done     <= 1'b0;
         timeout  <= 1'b0;
         byte_cnt <= '0;
         gap_cnt  <= '0;
         buf_q    <= '0;
      end else begin
         done    <= 1'b0;
         timeout <= 1'b0;
         // Leaving IDLE (a start edge) clears the gap counter.
         if ((byte_cnt != '0) && rx_idle) begin
            if (gap_cnt == GAP_LAST) begin
               timeout  <= 1'b1;
               byte_cnt <= '0;
               gap_cnt  <= '0;
            end else begin
               gap_cnt <= gap_cnt + 1'b1;
            end
         end else begin
            gap_cnt <= '0;
         end

         if (byte_ferr) begin
            byte_cnt <= '0;
         end else if (byte_valid) begin
            if (byte_cnt == LAST_SLOT) begin
               msg      <= buf_next;
               done     <= 1'b1;
               byte_cnt <= '0;
            end else begin
               buf_q    <= buf_next;
               byte_cnt <= byte_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_receiving_msg.sv
// Directed bench for uart_receiving_msg: serial stimulus generated in the bench,
// pulses counted by a negedge monitor, all expectations hand-computed constants.
module tb_uart_receiving_msg;

   localparam int BIT = 104;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        rx    = 1'b1;
   logic [47:0] msg;
   logic        done;
   logic        busy;
   logic        frame_error;
   logic        timeout;

   int total = 0;
   int bad   = 0;
   int n_done = 0;
   int n_ferr = 0;
   int n_tout = 0;
   int n_excl = 0;
   logic [47:0] done_q[$];

   uart_receiving_msg #(
      .clk_freq      (1000000),
      .baud_rate     (9600),
      .msg_size_byte (6),
      .timeout_bits  (20)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .msg         (msg),
      .done        (done),
      .busy        (busy),
      .frame_error (frame_error),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (done) begin
            n_done++;
            done_q.push_back(msg);
         end
         if (frame_error) n_ferr++;
         if (timeout) n_tout++;
         if (done && (frame_error || timeout)) n_excl++;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      wait_clk(BIT);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clk(BIT);
      end
      rx = stop_bit;
      wait_clk(BIT);
      rx = 1'b1;
   endtask

   task automatic send_msg(input logic [47:0] m);
      for (int i = 0; i < 6; i++) send_byte(m[8*i +: 8], 1'b1);
   endtask

   int d0, f0, t0, q0;
   logic [7:0] partial;
   logic [47:0] got1, got2;

   initial begin
      reset = 1'b1;
      rx    = 1'b1;
      wait_clk(5);
      @(negedge clk);
      check_eq("rst_msg", 64'(msg), 64'd0);
      check_eq("rst_pulses", 64'({done, busy, frame_error, timeout}), 64'd0);
      reset = 1'b0;
      wait_clk(10);

      // loopback
      d0 = n_done;
      send_msg(48'hE8E901020304);
      wait_clk(20);
      @(negedge clk);
      check_eq("lb_done_cnt", 64'(n_done - d0), 64'd1);
      check_eq("lb_msg", 64'(msg), 64'h0000_E8E901020304);
      check_eq("lb_busy", 64'(busy), 64'd0);
      check_eq("lb_errs", 64'(n_ferr + n_tout), 64'd0);

      // glitch: busy may rise while the start bit is qualified, so check after
      d0 = n_done; f0 = n_ferr; t0 = n_tout;
      rx = 1'b0;
      wait_clk(20);
      rx = 1'b1;
      wait_clk(100);
      @(negedge clk);
      check_eq("gl_busy", 64'(busy), 64'd0);
      check_eq("gl_pulses", 64'((n_done - d0) + (n_ferr - f0) + (n_tout - t0)), 64'd0);
      check_eq("gl_msg", 64'(msg), 64'h0000_E8E901020304);

      // frame error then full message
      d0 = n_done; f0 = n_ferr;
      send_byte(8'h55, 1'b0);
      wait_clk(2 * BIT);
      @(negedge clk);
      check_eq("fe_cnt", 64'(n_ferr - f0), 64'd1);
      check_eq("fe_msg_kept", 64'(msg), 64'h0000_E8E901020304);
      check_eq("fe_busy", 64'(busy), 64'd0);
      send_msg(48'h0A0B0C0D0E0F);
      wait_clk(20);
      @(negedge clk);
      check_eq("fe_done_cnt", 64'(n_done - d0), 64'd1);
      check_eq("fe_msg", 64'(msg), 64'h0000_0A0B0C0D0E0F);

      // inter-byte timeout
      d0 = n_done; t0 = n_tout;
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1);
      @(negedge clk);
      check_eq("to_busy_partial", 64'(busy), 64'd1);
      wait_clk(25 * BIT);
      @(negedge clk);
      check_eq("to_cnt", 64'(n_tout - t0), 64'd1);
      check_eq("to_busy_after", 64'(busy), 64'd0);
      check_eq("to_no_done", 64'(n_done - d0), 64'd0);
      check_eq("to_msg_kept", 64'(msg), 64'h0000_0A0B0C0D0E0F);
      send_msg(48'h112233445566);
      wait_clk(20);
      @(negedge clk);
      check_eq("to_done_cnt", 64'(n_done - d0), 64'd1);
      check_eq("to_msg", 64'(msg), 64'h0000_112233445566);

      // reset during bit 4 of byte 2
      d0 = n_done;
      send_byte(8'hA1, 1'b1);
      send_byte(8'hA2, 1'b1);
      partial = 8'hA3;
      rx = 1'b0;
      wait_clk(BIT);
      for (int i = 0; i < 4; i++) begin
         rx = partial[i];
         wait_clk(BIT);
      end
      rx = partial[4];
      wait_clk(BIT / 2);
      reset = 1'b1;
      rx    = 1'b1;
      @(negedge clk);
      check_eq("mr_msg", 64'(msg), 64'd0);
      check_eq("mr_outs", 64'({done, busy, frame_error, timeout}), 64'd0);
      wait_clk(10);
      @(negedge clk);
      reset = 1'b0;
      wait_clk(2 * BIT);
      @(negedge clk);
      check_eq("mr_idle", 64'({busy, done}), 64'd0);
      check_eq("mr_no_done", 64'(n_done - d0), 64'd0);
      send_msg(48'hA6A5A4A3A2A1);
      wait_clk(20);
      @(negedge clk);
      check_eq("mr_done_cnt", 64'(n_done - d0), 64'd1);
      check_eq("mr_msg_resent", 64'(msg), 64'h0000_A6A5A4A3A2A1);

      // back-to-back, zero idle between all bytes
      d0 = n_done; f0 = n_ferr; t0 = n_tout;
      q0 = done_q.size();
      send_msg(48'hC0FFEE123456);
      send_msg(48'h5A5AA5A50F0F);
      wait_clk(20);
      @(negedge clk);
      check_eq("bb_done_cnt", 64'(n_done - d0), 64'd2);
      got1 = (done_q.size() > q0) ? done_q[q0] : 48'd0;
      got2 = (done_q.size() > q0 + 1) ? done_q[q0 + 1] : 48'd0;
      check_eq("bb_msg1", 64'(got1), 64'h0000_C0FFEE123456);
      check_eq("bb_msg2", 64'(got2), 64'h0000_5A5AA5A50F0F);
      check_eq("bb_errs", 64'((n_ferr - f0) + (n_tout - t0)), 64'd0);
      check_eq("bb_busy", 64'(busy), 64'd0);

      check_eq("pulse_exclusive", 64'(n_excl), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_receiving_msg.md
# uart_receiving_msg

UART receiver that assembles a fixed-length multi-byte message from a serial `rx` line and presents it as one wide word with a single-cycle `done` pulse. It is the receiving end of `uart_sending_msg`: same framing, same byte order, same parameter names, so the two can be looped back directly. It is intended as a test-side monitor for controller `tx` output, and as a host-command input block in larger designs.

## Interface
- `clk_freq`, 1000000: clock frequency in Hz.
- `baud_rate`, 9600: line rate in bit/s.
- `msg_size_byte`, 6: number of bytes per message, ≥1.
- `timeout_bits`, 20: maximum idle gap between bytes of one message, in bit periods.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `rx` in 1: serial input, idle high; asynchronous to `clk`.
- `msg` out 8*msg_size_byte: last complete message. First received byte is in bits [7:0].
- `done` out 1: one-cycle pulse when `msg` is updated.
- `busy` out 1: high while a message is partially received.
- `frame_error` out 1: one-cycle pulse when a stop bit is sampled low.
- `timeout` out 1: one-cycle pulse when a partial message is discarded for inter-byte gap.

## Operation
- Framing is 8N1, LSB first: 1 start bit (0), 8 data bits, 1 stop bit (1). There is no parity.
- Bit period `BIT = clk_freq / baud_rate`, using truncating integer division. `HALF = BIT / 2`.
- `rx` passes through a 2-flop synchroniser, reset to 1. All logic uses the synchronised `rx_s`.
- Byte FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a falling edge on `rx_s` moves to START and clears the bit counter.
  - START: after HALF cycles, sample `rx_s`. If 0, go to DATA. If 1, treat the edge as a glitch and return to IDLE, with no output and no counter change.
  - DATA: every BIT cycles after the start-bit midpoint, sample one bit into a shift register, LSB first. After 8 samples, go to STOP.
  - STOP: after BIT cycles, sample `rx_s`.
    - If 1: write the byte into slot `byte_cnt` of the assembly buffer, increment `byte_cnt`, and go to IDLE.
    - If 0: pulse `frame_error`, discard the whole partial message (`byte_cnt`←0), and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s` = 1, then go to IDLE.
- Message completion: when the byte just accepted is number `msg_size_byte`-1:
  - `msg` ← assembly buffer, including that byte;
  - `done` pulses;
  - `byte_cnt` ← 0.
- `msg` keeps its value until the next complete message. A partial or erroneous message never changes `msg`.
- Inter-byte timeout:
  - When 0 < `byte_cnt` and the FSM is in IDLE, a gap counter runs.
  - When it reaches `timeout_bits*BIT`, `timeout` pulses and `byte_cnt` ← 0.
  - The counter clears on any start edge.
- `busy` = (`byte_cnt` ≠ 0) or (FSM ≠ IDLE).
- With `msg_size_byte` = 1, every valid byte produces `done`, and the timeout never fires.

## Timing
- Reset values:
  - `msg` = 0, `done` = 0, `busy` = 0, `frame_error` = 0, `timeout` = 0.
  - FSM in IDLE, `byte_cnt` = 0, synchroniser flops = 1.
- Reset asserted mid-message: all state clears immediately. After release, the receiver waits for a fresh falling edge.
- Latency: `done` rises 1 cycle after the stop-bit sample of the last byte. That is ≈ 2 + HALF + 9·BIT + 1 cycles after the start-bit falling edge on `rx`. `msg` is valid in the same cycle as `done`.
- `frame_error` and `timeout` are 1-cycle pulses and mutually exclusive with `done`.
- A start edge in the same cycle as a timeout expiry: the timeout wins. The new byte starts message slot 0.
- Back-to-back bytes with zero idle between the stop bit and the next start bit are received without loss. The STOP→IDLE transition completes at the stop-bit midpoint.

## Structure
- A shared package/header holds:
  - the FSM state encoding;
  - the BIT/HALF computation, shared with `uart_sending_msg` so both ends agree on rounding.
- A natural sub-module is `uart_rx_byte`. It contains the synchroniser, the byte FSM and the shift register, and outputs `byte`, `byte_valid` and `frame_error`.
- The top level holds the assembly buffer, `byte_cnt`, the timeout counter and `msg`/`done`.

## Test plan
Common settings: `clk_freq` = 1000000, `baud_rate` = 9600 (BIT = 104), `msg_size_byte` = 6.
- Loopback: `uart_sending_msg` sends 48'hE8E901020304. Required: exactly one `done` pulse, with `msg` = 48'hE8E901020304 and `busy` low afterwards.
- Glitch: `rx` is driven low for 20 cycles in IDLE. Required: no state change, `busy` stays 0, no pulses.
- Frame error: byte 0x55 is sent with the stop bit forced to 0, then the full 6-byte message 48'h0A0B0C0D0E0F. Required:
  - one `frame_error` pulse;
  - then one `done` with `msg` = 48'h0A0B0C0D0E0F;
  - `msg` unchanged in between.
- Timeout: 3 bytes are sent, then `rx` idles for 25·BIT, then 6 bytes 48'h112233445566. Required: one `timeout` pulse, then `done` with `msg` = 48'h112233445566.
- Reset mid-byte: `reset` is asserted during bit 4 of byte 2, then the full message is resent. Required:
  - all outputs are 0 during reset;
  - only the resent message produces `done`, with the correct value.
- Back-to-back: 2 messages are sent with zero idle gaps. Required: two `done` pulses, each with the correct `msg`, and no errors.
